// File: rtl/morse_decoder.sv
// Morse key decoder: synchronises and debounces a raw key, classifies presses as
// dot/dash, accumulates up to five symbols and emits a decoded letter or space.
module morse_decoder #(
  parameter int DEBOUNCE_CYC   = 250000,
  parameter int DOT_MAX_CYC    = 5000000,
  parameter int LETTER_GAP_CYC = 12500000,
  parameter int WORD_GAP_CYC   = 37500000,
  parameter int CNT_W          = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       key_level,
  output logic [2:0] sym_count,
  output logic       err
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [2:0] {IDLE, PRESS, GAP, EMIT, WORD_WAIT} state_t;

  state_t           state, next_state;
  logic             sync1, sync2;
  logic [DB_W-1:0]  db_cnt;
  logic [CNT_W-1:0] dur_cnt;
  logic [3:0]       sym_reg;
  logic             ovf;
  logic             kl_toggle, kl_rise, kl_fall, is_dash;
  logic             append, clear_letter, load_out, out_err;
  logic [7:0]       out_code, decoded;

  // The duration counter restarts on the same edge key_level changes, so it reads 0
  // in the first cycle of the new level.
  assign kl_toggle = (sync2 != key_level) && (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
  assign kl_rise   = kl_toggle && !key_level;
  assign kl_fall   = kl_toggle && key_level;
  assign is_dash   = dur_cnt >= CNT_W'(DOT_MAX_CYC);

  function automatic logic [7:0] decode(input logic [2:0] n, input logic [3:0] s);
    logic [7:0] r;
    r = 8'h00;
    case (n)
      3'd1: r = s[0] ? 8'h54 : 8'h45;
      3'd2: case (s[1:0])
        2'b00: r = 8'h49; 2'b01: r = 8'h41; 2'b10: r = 8'h4E; default: r = 8'h4D;
      endcase
      3'd3: case (s[2:0])
        3'b000: r = 8'h53; 3'b001: r = 8'h55; 3'b010: r = 8'h52; 3'b011: r = 8'h57;
        3'b100: r = 8'h44; 3'b101: r = 8'h4B; 3'b110: r = 8'h47; default: r = 8'h4F;
      endcase
      3'd4: case (s)
        4'b0000: r = 8'h48; 4'b0001: r = 8'h56; 4'b0010: r = 8'h46; 4'b0100: r = 8'h4C;
        4'b0110: r = 8'h50; 4'b0111: r = 8'h4A; 4'b1000: r = 8'h42; 4'b1001: r = 8'h58;
        4'b1010: r = 8'h43; 4'b1011: r = 8'h59; 4'b1100: r = 8'h5A; 4'b1101: r = 8'h51;
        default: r = 8'h00;
      endcase
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign decoded = decode(sym_count, sym_reg);

  always_comb begin
    next_state   = state;
    append       = 1'b0;
    clear_letter = 1'b0;
    load_out     = 1'b0;
    out_code     = 8'h00;
    out_err      = 1'b0;
    case (state)
      IDLE: if (kl_rise) next_state = PRESS;
      PRESS: if (kl_fall) begin
        append     = 1'b1;
        next_state = GAP;
      end
      GAP: begin
        if (kl_rise) next_state = PRESS;
        else if (dur_cnt == CNT_W'(LETTER_GAP_CYC - 1)) begin
          next_state = EMIT;
          load_out   = 1'b1;
          out_code   = ovf ? 8'h00 : decoded;
          out_err    = ovf || (decoded == 8'h00);
        end
      end
      EMIT: begin
        clear_letter = 1'b1;
        next_state   = kl_rise ? PRESS : WORD_WAIT;
      end
      WORD_WAIT: begin
        if (kl_rise) next_state = PRESS;
        else if (dur_cnt == CNT_W'(WORD_GAP_CYC - 1)) begin
          next_state = IDLE;
          load_out   = 1'b1;
          out_code   = 8'hFF;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= '0;
      key_level <= 1'b0;
      dur_cnt   <= '0;
    end else begin
      state <= next_state;
      sync1 <= key_in;
      sync2 <= sync1;
      if (kl_toggle) begin
        key_level <= ~key_level;
        db_cnt    <= '0;
      end else if (sync2 != key_level) db_cnt <= db_cnt + 1'b1;
      else db_cnt <= '0;
      if (kl_toggle) dur_cnt <= '0;
      else if (dur_cnt != '1) dur_cnt <= dur_cnt + 1'b1;
    end
  end

  // Symbol accumulation; bits beyond the fourth symbol never affect decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_reg   <= '0;
      sym_count <= '0;
      ovf       <= 1'b0;
    end else if (clear_letter) begin
      sym_reg   <= '0;
      sym_count <= '0;
      ovf       <= 1'b0;
    end else if (append) begin
      sym_reg <= {sym_reg[2:0], is_dash};
      if (sym_count < 3'd5) sym_count <= sym_count + 1'b1;
      else ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      letter       <= 8'h00;
      letter_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      letter_valid <= load_out;
      err          <= load_out && out_err;
      if (load_out) letter <= out_code;
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: a driver shapes key presses, a monitor pops the
// expected {err, letter} queue on every strobe.
module tb_morse_decoder;
  localparam int DEBOUNCE_CYC   = 4;
  localparam int DOT_MAX_CYC    = 20;
  localparam int LETTER_GAP_CYC = 50;
  localparam int WORD_GAP_CYC   = 150;
  localparam int CNT_W          = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in = 1'b0;
  logic [7:0] letter;
  logic       letter_valid, key_level, err;
  logic [2:0] sym_count;

  morse_decoder #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .DOT_MAX_CYC(DOT_MAX_CYC),
    .LETTER_GAP_CYC(LETTER_GAP_CYC), .WORD_GAP_CYC(WORD_GAP_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .letter(letter),
    .letter_valid(letter_valid), .key_level(key_level), .sym_count(sym_count), .err(err)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         strobe_cyc = -1000;
  int         prev_strobe_cyc = -1000;
  int         fall_cyc = -2000;
  logic       kl_prev = 1'b0;
  logic       prev_valid = 1'b0;
  logic       kl_seen_high = 1'b0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_key(input logic v, input int n);
    key_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every strobe must match the head of the expected queue.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!key_level && kl_prev) fall_cyc = cyc;
        if (key_level) kl_seen_high = 1'b1;
        if (letter_valid) begin
          check("no_back_to_back_strobe", int'(prev_valid), 0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_strobe: got %0h, expected no strobe (cycle %0d)",
                     {err, letter}, cyc);
          end else begin
            e = exp_q.pop_front();
            check("strobe_err_letter", int'({err, letter}), int'(e));
          end
          prev_strobe_cyc = strobe_cyc;
          strobe_cyc      = cyc;
        end
      end
      kl_prev    = key_level;
      prev_valid = letter_valid;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_letter", int'(letter), 0);
    check("reset_valid", int'(letter_valid), 0);
    check("reset_key_level", int'(key_level), 0);
    check("reset_sym_count", int'(sym_count), 0);
    check("reset_err", int'(err), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single dot -> E, exact letter-gap latency
    exp_q.push_back({1'b0, 8'h45});
    drive_key(1'b1, 10);
    drive_key(1'b0, 10);
    check("t1_sym_count_one", int'(sym_count), 1);
    drive_key(1'b0, 50);
    check("t1_sym_count_cleared", int'(sym_count), 0);
    check("t1_latency", strobe_cyc - fall_cyc, LETTER_GAP_CYC);
    check("t1_letter_hold", int'(letter), 8'h45);

    // 2: dot dash -> A, then space 100 cycles later
    exp_q.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b0, 8'hFF});
    drive_key(1'b1, 10);
    drive_key(1'b0, 10);
    drive_key(1'b1, 30);
    drive_key(1'b0, 200);
    check("t2_space_spacing", strobe_cyc - prev_strobe_cyc, WORD_GAP_CYC - LETTER_GAP_CYC);
    check("t2_space_hold", int'(letter), 8'hFF);

    // 3: six dots -> overflow, 0x00 with err
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    repeat (6) begin
      drive_key(1'b1, 10);
      drive_key(1'b0, 10);
    end
    check("t3_sym_count_sat", int'(sym_count), 5);
    drive_key(1'b0, 190);

    // 4: glitches never reach key_level; then dash -> T
    kl_seen_high = 1'b0;
    repeat (4) begin
      drive_key(1'b1, 2);
      drive_key(1'b0, 10);
    end
    check("t4_glitch_key_level", int'(kl_seen_high), 0);
    exp_q.push_back({1'b0, 8'h54});
    exp_q.push_back({1'b0, 8'hFF});
    drive_key(1'b1, 30);
    drive_key(1'b0, 200);

    // 5: new press in WORD_WAIT suppresses the space
    exp_q.push_back({1'b0, 8'h54});
    exp_q.push_back({1'b0, 8'h45});
    exp_q.push_back({1'b0, 8'hFF});
    drive_key(1'b1, 30);
    drive_key(1'b0, 70);
    drive_key(1'b1, 10);
    drive_key(1'b0, 200);

    // 6: reset mid-press after two symbols discards the letter
    drive_key(1'b1, 10);
    drive_key(1'b0, 10);
    drive_key(1'b1, 10);
    drive_key(1'b0, 10);
    drive_key(1'b1, 10);
    check("t6_sym_count_before_reset", int'(sym_count), 2);
    rst_n = 1'b0;
    #1;
    check("t6_reset_letter", int'(letter), 0);
    check("t6_reset_valid", int'(letter_valid), 0);
    check("t6_reset_key_level", int'(key_level), 0);
    check("t6_reset_sym_count", int'(sym_count), 0);
    check("t6_reset_err", int'(err), 0);
    key_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    drive_key(1'b0, 20);
    exp_q.push_back({1'b0, 8'h45});
    exp_q.push_back({1'b0, 8'hFF});
    drive_key(1'b1, 10);
    drive_key(1'b0, 200);

    drive_key(1'b0, 20);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
